instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
- Inverse of the core's instruction decoder. Takes decoded instruction fields (type, opcode, funct3/funct7, register indices, immediate) and packs them into a 32-bit RV32 instruction word.
- Checks that the opcode is legal for the requested type and that the immediate fits its field. Illegal requests are flagged, not encoded.
- Sits between the self-test program generator and instruction memory. Valid/ready handshake on both sides, with a small output FIFO.

Parameters:
- FIFO_DEPTH, 2, output FIFO entries; power of two, ≥2.
- COUNT_WIDTH, 16, width of the legal-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request fields are valid.
- in_ready  output  1  encoder can accept a request.
- instruction_type  input  3  R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 are illegal.
- opcode  input  7  major opcode.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field (R only).
- read_index_1  input  5  rs1.
- read_index_2  input  5  rs2.
- write_index  input  5  rd.
- immediate  input  32  signed byte-offset / immediate value.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer takes the FIFO head.
- instruction  output  32  encoded word at the FIFO head.
- illegal  output  1  FIFO head entry is an illegal request.
- encoded_count  output  COUNT_WIDTH  legal words accepted; wraps.
- illegal_count  output  8  illegal requests accepted; saturates at 255.

Behaviour:
- Reset values:
  - out_valid=0, instruction=0, illegal=0.
  - encoded_count=0, illegal_count=0.
  - FIFO pointers cleared; in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all FIFO contents.
- Handshake:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = !full. No pass-through: when full, in_ready stays 0 even if out_ready=1 in the same cycle.
  - Push and pop in the same cycle (not full, not empty): occupancy unchanged.
  - Outputs are held stable while out_valid && !out_ready.
- Latency: an accepted request appears at the FIFO head (out_valid=1) in the next cycle if the FIFO was empty. Otherwise it appears in FIFO order.
- Opcode legality:
  - opcode[1:0] must be 2'b11.
  - opcode[6:2] must belong to the requested type:
    - I: 00000, 00001, 00100, 00110, 11001
    - S: 01000, 01001
    - B: 11000
    - R: 01100, 10100
    - U: 00101, 01101
    - J: 11011
- Immediate range checks (two's complement):
  - I and S: -2048..2047.
  - B: -4096..4094, with bit0=0.
  - J: -1048576..1048574, with bit0=0.
  - U: immediate[11:0] must be 0.
  - R: immediate ignored.
- Encoding (standard RV32):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - Unused input fields are ignored.
- Illegal requests (any failed check, or type 6/7):
  - Accepted normally and stored with instruction=32'h0000_0000, illegal=1.
  - Increment illegal_count (saturating).
- Legal requests: stored with illegal=0 and increment encoded_count at accept; the counter wraps modulo 2^COUNT_WIDTH.
- Counters update on the accept edge, not the pop edge.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 → out_valid=0, both counts 0; in_ready=1 after reset.
- Type I, opcode 0010011, funct3 0, rd 1, rs1 0, imm 5 → next cycle out_valid=1, instruction=0x00500093, illegal=0, encoded_count=1.
- Back-to-back with out_ready=1:
  - S: opcode 0100011, funct3 010, rs1 1, rs2 2, imm 8 → 0x0020A423.
  - B: opcode 1100011, funct3 0, rs1 0, rs2 0, imm -4 → 0xFE000EE3.
  - J: opcode 1101111, rd 1, imm 2048 → 0x001000EF.
  - R: opcode 0110011, funct7 0, rs1 1, rs2 2, rd 3 → 0x002081B3.
  - Required: in order, one per cycle.
- Illegal requests:
  - Type I with opcode 0110011 → illegal=1, instruction=0.
  - Type I with imm 2048 → illegal=1.
  - Type B with imm 6 → legal; type B with imm 5 → illegal.
  - illegal_count=3 after the four requests; encoded_count unchanged by the illegal ones.
- Backpressure: out_ready=0, drive 3 legal requests → in_ready=0 after 2 accepts, head stable. Then out_ready=1 → third request accepted one cycle later, output order preserved.
- Saturation/wrap: 300 illegal requests → illegal_count=255. Preload to 0xFFFF legal and push 1 more → encoded_count=0.

Source files
------------

// File: rtl/instruction_encoder.sv
// Packs decoded RV32 instruction fields into a 32-bit word, flagging illegal
// opcode/immediate combinations, and queues results in a small output FIFO.
module instruction_encoder #(
  parameter int FIFO_DEPTH  = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             instruction_type,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic [6:0]             funct7,
  input  logic [4:0]             read_index_1,
  input  logic [4:0]             read_index_2,
  input  logic [4:0]             write_index,
  input  logic [31:0]            immediate,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            instruction,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] encoded_count,
  output logic [7:0]             illegal_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    TYPE_R = 3'd0,
    TYPE_I = 3'd1,
    TYPE_S = 3'd2,
    TYPE_B = 3'd3,
    TYPE_U = 3'd4,
    TYPE_J = 3'd5
  } instr_type_e;

  logic [4:0]  w_major;
  logic        w_fits12;
  logic        w_fits13;
  logic        w_fits21;
  logic        w_opLegal;
  logic        w_immLegal;
  logic        w_legal;
  logic [31:0] w_word;

  assign w_major = opcode[6:2];

  // Sign-extension checks: all bits above the field's sign bit must match it.
  assign w_fits12 = (immediate[31:11] == '0) || (immediate[31:11] == '1);
  assign w_fits13 = (immediate[31:12] == '0) || (immediate[31:12] == '1);
  assign w_fits21 = (immediate[31:20] == '0) || (immediate[31:20] == '1);

  always_comb begin
    w_opLegal  = 1'b0;
    w_immLegal = 1'b0;
    w_word     = '0;
    case (instruction_type)
      TYPE_R: begin
        w_opLegal  = (w_major == 5'b01100) || (w_major == 5'b10100);
        w_immLegal = 1'b1;
        w_word     = {funct7, read_index_2, read_index_1, funct3, write_index, opcode};
      end
      TYPE_I: begin
        w_opLegal  = (w_major == 5'b00000) || (w_major == 5'b00001) ||
                     (w_major == 5'b00100) || (w_major == 5'b00110) ||
                     (w_major == 5'b11001);
        w_immLegal = w_fits12;
        w_word     = {immediate[11:0], read_index_1, funct3, write_index, opcode};
      end
      TYPE_S: begin
        w_opLegal  = (w_major == 5'b01000) || (w_major == 5'b01001);
        w_immLegal = w_fits12;
        w_word     = {immediate[11:5], read_index_2, read_index_1, funct3,
                      immediate[4:0], opcode};
      end
      TYPE_B: begin
        w_opLegal  = (w_major == 5'b11000);
        w_immLegal = w_fits13 && !immediate[0];
        w_word     = {immediate[12], immediate[10:5], read_index_2, read_index_1,
                      funct3, immediate[4:1], immediate[11], opcode};
      end
      TYPE_U: begin
        w_opLegal  = (w_major == 5'b00101) || (w_major == 5'b01101);
        w_immLegal = (immediate[11:0] == 12'h000);
        w_word     = {immediate[31:12], write_index, opcode};
      end
      TYPE_J: begin
        w_opLegal  = (w_major == 5'b11011);
        w_immLegal = w_fits21 && !immediate[0];
        w_word     = {immediate[20], immediate[10:1], immediate[11],
                      immediate[19:12], write_index, opcode};
      end
      default: begin
        w_opLegal  = 1'b0;
        w_immLegal = 1'b0;
        w_word     = '0;
      end
    endcase
  end

  assign w_legal = w_opLegal && w_immLegal && (opcode[1:0] == 2'b11);

  logic [31:0] r_memWord    [FIFO_DEPTH];
  logic        r_memIllegal [FIFO_DEPTH];
  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic [AW:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count  = r_wrPtr - r_rdPtr;
  assign w_full   = (w_count == (AW + 1)'(FIFO_DEPTH));
  assign w_empty  = (r_wrPtr == r_rdPtr);
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Illegal requests are stored as an all-zero word with the flag set.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memWord[r_wrPtr[AW-1:0]]    <= w_legal ? w_word : 32'h0000_0000;
      r_memIllegal[r_wrPtr[AW-1:0]] <= !w_legal;
    end
  end

  assign out_valid   = !w_empty;
  assign instruction = out_valid ? r_memWord[r_rdPtr[AW-1:0]] : 32'h0000_0000;
  assign illegal     = out_valid ? r_memIllegal[r_rdPtr[AW-1:0]] : 1'b0;

  logic [COUNT_WIDTH-1:0] r_encodedCount;
  logic [7:0]             r_illegalCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_encodedCount <= '0;
      r_illegalCount <= '0;
    end else if (w_push) begin
      if (w_legal) begin
        r_encodedCount <= r_encodedCount + 1'b1;
      end else if (r_illegalCount != 8'hFF) begin
        r_illegalCount <= r_illegalCount + 1'b1;
      end
    end
  end

  assign encoded_count = r_encodedCount;
  assign illegal_count = r_illegalCount;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder; counter width is shrunk to 8 bits
// so the wrap case is reachable in a few hundred cycles.
module tb_instruction_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  instruction_type;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  read_index_1;
  logic [4:0]  read_index_2;
  logic [4:0]  write_index;
  logic [31:0] immediate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic        illegal;
  logic [7:0]  encoded_count;
  logic [7:0]  illegal_count;

  int vectors     = 0;
  int miscompares = 0;

  instruction_encoder #(
    .FIFO_DEPTH (2),
    .COUNT_WIDTH(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .instruction_type(instruction_type),
    .opcode          (opcode),
    .funct3          (funct3),
    .funct7          (funct7),
    .read_index_1    (read_index_1),
    .read_index_2    (read_index_2),
    .write_index     (write_index),
    .immediate       (immediate),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .instruction     (instruction),
    .illegal         (illegal),
    .encoded_count   (encoded_count),
    .illegal_count   (illegal_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] typ, input logic [6:0] op,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] imm);
    instruction_type = typ;
    opcode           = op;
    funct3           = f3;
    funct7           = f7;
    read_index_1     = rs1;
    read_index_2     = rs2;
    write_index      = rd;
    immediate        = imm;
    in_valid         = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Head of FIFO: valid flag, word and illegal flag together.
  task automatic checkHead(input string tag, input logic [31:0] word,
                           input logic ill);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_word"}, instruction, word);
    checkOutput({tag, "_illegal"}, 32'(illegal), 32'(ill));
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);

    // Reset held two cycles while in_valid is asserted
    tick();
    tick();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_instruction", instruction, 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    checkOutput("rst_encoded", 32'(encoded_count), 32'd0);
    checkOutput("rst_illegal_cnt", 32'(illegal_count), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // Single I-type: addi x1, x0, 5
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    tick();
    in_valid = 1'b0;
    checkHead("itype", 32'h0050_0093, 1'b0);
    checkOutput("itype_encoded", 32'(encoded_count), 32'd1);
    out_ready = 1'b1;
    tick();
    checkOutput("itype_popped", 32'(out_valid), 32'd0);

    // Back-to-back S, B, J, R with the consumer always ready
    applyStimulus(3'd2, 7'b0100011, 3'b010, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
    tick();
    checkHead("s", 32'h0020_A423, 1'b0);
    applyStimulus(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    tick();
    checkHead("b", 32'hFE00_0EE3, 1'b0);
    applyStimulus(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
    tick();
    checkHead("j", 32'h0010_00EF, 1'b0);
    applyStimulus(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
    tick();
    checkHead("r", 32'h0020_81B3, 1'b0);
    in_valid = 1'b0;
    tick();
    checkOutput("b2b_drained", 32'(out_valid), 32'd0);
    checkOutput("b2b_encoded", 32'(encoded_count), 32'd5);

    // Illegal opcode, out-of-range immediate, B alignment boundary
    applyStimulus(3'd1, 7'b0110011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd0);
    tick();
    checkHead("ill_opcode", 32'h0, 1'b1);
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
    tick();
    checkHead("ill_imm2048", 32'h0, 1'b1);
    applyStimulus(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd6);
    tick();
    checkHead("b_imm6", 32'h0000_0363, 1'b0);
    applyStimulus(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5);
    tick();
    checkHead("b_imm5", 32'h0, 1'b1);
    in_valid = 1'b0;
    tick();
    checkOutput("ill_count3", 32'(illegal_count), 32'd3);
    checkOutput("ill_encoded", 32'(encoded_count), 32'd6);

    // U type, I lower immediate bound, reserved type 6, U with low bits set
    applyStimulus(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000);
    tick();
    checkHead("u_lui", 32'h1234_52B7, 1'b0);
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800);
    tick();
    checkHead("i_min", 32'h8000_0013, 1'b0);
    applyStimulus(3'd6, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd0);
    tick();
    checkHead("type6", 32'h0, 1'b1);
    applyStimulus(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5001);
    tick();
    checkHead("u_lowbits", 32'h0, 1'b1);
    in_valid = 1'b0;
    tick();
    checkOutput("mix_ill_count", 32'(illegal_count), 32'd5);
    checkOutput("mix_encoded", 32'(encoded_count), 32'd8);

    // Backpressure: FIFO fills after two accepts, head stays put
    out_ready = 1'b0;
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1);
    tick();
    checkHead("bp_a", 32'h0010_0093, 1'b0);
    checkOutput("bp_ready_a", 32'(in_ready), 32'd1);
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2);
    tick();
    checkHead("bp_a_hold", 32'h0010_0093, 1'b0);
    checkOutput("bp_full", 32'(in_ready), 32'd0);
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd3);
    tick();
    checkHead("bp_a_stall", 32'h0010_0093, 1'b0);
    checkOutput("bp_full_hold", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    checkHead("bp_b", 32'h0020_0093, 1'b0);
    checkOutput("bp_no_passthru", 32'(encoded_count), 32'd10);
    tick();
    in_valid = 1'b0;
    checkHead("bp_c", 32'h0030_0093, 1'b0);
    checkOutput("bp_encoded", 32'(encoded_count), 32'd11);
    tick();
    checkOutput("bp_drained", 32'(out_valid), 32'd0);

    // Saturation of the illegal counter
    applyStimulus(3'd7, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd0);
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    tick();
    checkOutput("ill_saturate", 32'(illegal_count), 32'd255);

    // Wrap of the legal counter: 244 more reach 255, one more wraps to 0
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd9);
    for (int i = 0; i < 244; i++) tick();
    in_valid = 1'b0;
    tick();
    checkOutput("enc_max", 32'(encoded_count), 32'd255);
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd9);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("enc_wrap", 32'(encoded_count), 32'd0);
    checkOutput("wrap_ill_hold", 32'(illegal_count), 32'd255);

    // Reset while the FIFO is full discards its contents
    out_ready = 1'b0;
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd4);
    tick();
    tick();
    in_valid = 1'b0;
    checkOutput("pre_rst_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_ill_cnt", 32'(illegal_count), 32'd0);
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd7);
    tick();
    in_valid = 1'b0;
    checkHead("post_rst", 32'h0070_0093, 1'b0);
    checkOutput("post_rst_encoded", 32'(encoded_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
